// File: rtl/proc_ctrl.sv
// Control unit for the simple processor: a T0..T3 step counter plus a purely
// combinational decode of step, instruction and Gnz into datapath strobes.
module proc_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       Gnz,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       DINout,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] Tstep
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  step_t      step, next_step;
  logic [2:0] opcode, reg_x, reg_y;
  logic       is_alu;

  assign opcode = IR[8:6];
  assign reg_x  = IR[5:3];
  assign reg_y  = IR[2:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign Tstep  = step;

  always_ff @(posedge Clock) begin
    if (Reset) step <= T0;
    else       step <= next_step;
  end

  // IR is not latched: the decode relies on it staying stable until Done.
  always_comb begin
    next_step = step;
    IRin      = 1'b0;
    Rin       = 8'h00;
    Rout      = 8'h00;
    Ain       = 1'b0;
    Gin       = 1'b0;
    Gout      = 1'b0;
    DINout    = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;
    case (step)
      T0: begin
        IRin = Run;
        if (Run) next_step = T1;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            Rout[reg_y] = 1'b1;
            Rin[reg_x]  = 1'b1;
            Done        = 1'b1;
          end
          OP_MVI: begin
            DINout     = 1'b1;
            Rin[reg_x] = 1'b1;
            Done       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout[reg_x] = 1'b1;
            Ain         = 1'b1;
          end
          OP_MVNZ: begin
            Done = 1'b1;
            if (Gnz) begin
              Rout[reg_y] = 1'b1;
              Rin[reg_x]  = 1'b1;
            end
          end
          default: Done = 1'b1;
        endcase
        next_step = Done ? T0 : T2;
      end
      T2: begin
        // Only add/sub reach T2; any other decode here just falls back to T0.
        if (is_alu) begin
          Rout[reg_y] = 1'b1;
          Gin         = 1'b1;
          AddSub      = (opcode == OP_SUB);
          next_step   = T3;
        end else begin
          next_step = T0;
        end
      end
      T3: begin
        if (is_alu) begin
          Gout       = 1'b1;
          Rin[reg_x] = 1'b1;
          Done       = 1'b1;
        end
        next_step = T0;
      end
      default: next_step = T0;
    endcase
    // Reset silences every strobe in the same cycle, not just after the edge.
    if (Reset) begin
      IRin   = 1'b0;
      Rin    = 8'h00;
      Rout   = 8'h00;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: a driver pushes the expected output word
// for every cycle it drives; a negedge monitor pops and compares.
module tb_proc_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] IR;
  logic       Gnz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       DINout;
  logic       AddSub;
  logic       Done;
  logic [1:0] Tstep;

  localparam int W = 25;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  proc_ctrl dut (
    .Clock (Clock),
    .Reset (Reset),
    .Run   (Run),
    .IR    (IR),
    .Gnz   (Gnz),
    .IRin  (IRin),
    .Rin   (Rin),
    .Rout  (Rout),
    .Ain   (Ain),
    .Gin   (Gin),
    .Gout  (Gout),
    .DINout(DINout),
    .AddSub(AddSub),
    .Done  (Done),
    .Tstep (Tstep)
  );

  always #5 Clock = ~Clock;

  // Reference model: output word {IRin,Rin,Rout,Ain,Gin,Gout,DINout,AddSub,Done,Tstep}
  // for cycle k of an instruction (k=0 is the T0 cycle that samples Run).
  function automatic logic [W-1:0] model(input int k, input logic [8:0] ir,
                                         input logic gnz, input logic run,
                                         input logic rst);
    logic [7:0] rx, ry, r_in, r_out;
    logic irin, ain, gin, gout, din, addsub, done;
    int op;
    rx = 8'd1 << ir[5:3];
    ry = 8'd1 << ir[2:0];
    op = int'(ir[8:6]);
    {irin, ain, gin, gout, din, addsub, done} = 7'b0;
    r_in = 8'h00;
    r_out = 8'h00;
    if (!rst) begin
      if (k == 0) irin = run;
      else if (k == 1) begin
        if (op == 0) begin r_out = ry; r_in = rx; done = 1; end
        else if (op == 1) begin din = 1; r_in = rx; done = 1; end
        else if (op == 2 || op == 3) begin r_out = rx; ain = 1; end
        else if (op == 4) begin done = 1; if (gnz) begin r_out = ry; r_in = rx; end end
        else done = 1;
      end else if (k == 2) begin
        r_out = ry; gin = 1; addsub = (op == 3);
      end else begin
        gout = 1; r_in = rx; done = 1;
      end
    end
    return {irin, r_in, r_out, ain, gin, gout, din, addsub, done, 2'(k)};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [8:0] ir, input logic gnz, input logic hold);
    int n;
    n = (ir[8:7] == 2'b01) ? 4 : 2;
    for (int k = 0; k < n; k++) begin
      Reset = 1'b0;
      Run = (k == 0) ? 1'b1 : hold;
      IR = ir;
      Gnz = gnz;
      exp_q.push_back(model(k, ir, gnz, Run, 1'b0));
      tick();
    end
  endtask

  task automatic idle(input logic [8:0] ir);
    Reset = 1'b0;
    Run = 1'b0;
    IR = ir;
    exp_q.push_back(model(0, ir, Gnz, 1'b0, 1'b0));
    tick();
  endtask

  always @(negedge Clock) begin
    logic [W-1:0] got, exp;
    if (mon_en && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got, exp);
      end
      checks++;
      if ($countones(Rout) + int'(Gout) + int'(DINout) > 1) begin
        errors++;
        $display("FAIL bus_exclusive t=%0t Rout=%h Gout=%b DINout=%b exp at most one driver",
                 $time, Rout, Gout, DINout);
      end
      checks++;
      if (!$onehot0(Rin) || !$onehot0(Rout)) begin
        errors++;
        $display("FAIL onehot t=%0t Rin=%h Rout=%h exp one-hot or zero", $time, Rin, Rout);
      end
    end
  end

  initial begin
    logic [8:0] rir;
    Reset = 1'b1;
    Run = 1'b1;
    IR = 9'b001_011_000;
    Gnz = 1'b0;
    tick();
    mon_en = 1'b1;
    // Reset held: Run=1 must not leak onto IRin.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(0, IR, Gnz, Run, 1'b1));
      tick();
    end
    issue(9'b001_011_000, 1'b0, 1'b0);   // mvi R3
    idle(9'b001_011_000);
    issue(9'b010_001_010, 1'b0, 1'b0);   // add R1,R2
    issue(9'b011_101_101, 1'b1, 1'b0);   // sub R5,R5
    issue(9'b100_000_111, 1'b0, 1'b0);   // mvnz, G zero
    issue(9'b100_000_111, 1'b1, 1'b0);   // mvnz, G nonzero
    issue(9'b000_100_100, 1'b0, 1'b0);   // mv R4,R4
    // Reset in T2 of add aborts it.
    rir = 9'b010_110_011;
    Reset = 1'b0; Run = 1'b1; IR = rir;
    exp_q.push_back(model(0, rir, Gnz, 1'b1, 1'b0)); tick();
    Run = 1'b0;
    exp_q.push_back(model(1, rir, Gnz, 1'b0, 1'b0)); tick();
    Reset = 1'b1;
    exp_q.push_back(model(2, rir, Gnz, 1'b0, 1'b1)); tick();
    Reset = 1'b0;
    exp_q.push_back(model(0, rir, Gnz, 1'b0, 1'b0)); tick();
    issue(9'b000_010_001, 1'b0, 1'b0);   // mv R2,R1 after abort
    // Run held high: mv, mvi, add, reserved back to back.
    issue(9'b000_001_000, 1'b0, 1'b1);
    issue(9'b001_111_000, 1'b0, 1'b1);
    issue(9'b010_000_110, 1'b0, 1'b1);
    issue(9'b111_111_111, 1'b1, 1'b1);
    idle(9'b111_111_111);
    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      rir = 9'($urandom_range(0, 511));
      issue(rir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int j = 0, nidle = $urandom_range(0, 2); j < nidle; j++) idle(rir);
    end
    Run = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
